// File: rtl/gpc3111_5_checker_if.sv
// GPC stimulus/response bus between the BIST checker and a gpc3111_5 counter.
// Also carries the run request and the result status of the checker.
interface gpc3111_5_checker_if;
  logic       start;
  logic       src0;
  logic       src1;
  logic       src2;
  logic [2:0] src3;
  logic [4:0] dst;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_count;
  logic [5:0] first_err_vec;
  logic [4:0] first_err_dst;

  modport master (
    input  start, dst,
    output src0, src1, src2, src3,
    output busy, done, pass,
    output err_count, first_err_vec, first_err_dst
  );

  modport slave (
    output start, dst,
    input  src0, src1, src2, src3,
    input  busy, done, pass,
    input  err_count, first_err_vec, first_err_dst
  );
endinterface

// File: rtl/gpc3111_5_checker.sv
// Exhaustive BIST driver/checker for the gpc3111_5 parallel counter.
// Applies all 64 vectors, latency-aligns dst and reports pass/errors.
module gpc3111_5_checker #(
  parameter int DUT_LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  gpc3111_5_checker_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [5:0] r_src;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       r_got;
  logic [6:0] r_err;
  logic [5:0] r_fvec;
  logic [4:0] r_fdst;

  logic       w_cmp_valid;
  logic [5:0] w_cmp_vec;
  logic [1:0] w_w8;
  logic [4:0] w_exp;
  logic       w_mis;
  logic       w_last;
  logic [6:0] w_err_nxt;

  generate
    if (DUT_LATENCY == 0) begin : g_comb
      assign w_cmp_valid = r_valid;
      assign w_cmp_vec   = r_src;
    end else begin : g_pipe
      logic       r_pv   [DUT_LATENCY];
      logic [5:0] r_pvec [DUT_LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DUT_LATENCY; k++) begin
            r_pv[k]   <= 1'b0;
            r_pvec[k] <= 6'd0;
          end
        end else begin
          r_pv[0]   <= r_valid;
          r_pvec[0] <= r_src;
          for (int k = 1; k < DUT_LATENCY; k++) begin
            r_pv[k]   <= r_pv[k-1];
            r_pvec[k] <= r_pvec[k-1];
          end
        end
      end

      assign w_cmp_valid = r_pv[DUT_LATENCY-1];
      assign w_cmp_vec   = r_pvec[DUT_LATENCY-1];
    end
  endgenerate

  // weights 1,2,4 fill the low three bits; the weight-8 sum sits above
  assign w_w8 = {1'b0, w_cmp_vec[3]}
              + {1'b0, w_cmp_vec[4]}
              + {1'b0, w_cmp_vec[5]};
  assign w_exp = {w_w8, w_cmp_vec[2:0]};

  assign w_mis     = w_cmp_valid && (bus.dst != w_exp);
  assign w_last    = w_cmp_valid && (w_cmp_vec == 6'd63);
  assign w_err_nxt = r_err + {6'd0, w_mis};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= 6'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_got   <= 1'b0;
      r_err   <= 7'd0;
      r_fvec  <= 6'd0;
      r_fdst  <= 5'd0;
    end else begin
      r_done <= 1'b0;
      if (w_mis) begin
        r_err <= w_err_nxt;
        if (!r_got) begin
          r_got  <= 1'b1;
          r_fvec <= w_cmp_vec;
          r_fdst <= bus.dst;
        end
      end
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_src   <= 6'd0;
            r_valid <= 1'b1;
            r_pass  <= 1'b0;
            r_got   <= 1'b0;
            r_err   <= 7'd0;
            r_fvec  <= 6'd0;
            r_fdst  <= 5'd0;
          end
        end
        S_RUN: begin
          if (r_src == 6'd63) begin
            r_src   <= 6'd0;
            r_valid <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_src <= r_src + 6'd1;
          end
          // with zero latency the last compare lands on the last issue edge
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 7'd0);
          end
        end
        S_DRAIN: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 7'd0);
          end
        end
      endcase
    end
  end

  assign bus.src0          = r_src[0];
  assign bus.src1          = r_src[1];
  assign bus.src2          = r_src[2];
  assign bus.src3          = r_src[5:3];
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pass          = r_pass;
  assign bus.err_count     = r_err;
  assign bus.first_err_vec = r_fvec;
  assign bus.first_err_dst = r_fdst;

endmodule

// File: tb/tb_gpc3111_5_checker.sv
// Bench for gpc3111_5_checker: correct, faulty and registered GPC models
// at latencies 0 and 2, plus restart, ignored-start and reset sequences.
module tb_gpc3111_5_checker;

  typedef struct {
    int sel;
    int mode;
    int poke;
    int len;
    int pass;
    int err;
    int fvec;
    int fdst;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic r_start;
  logic sel;
  int   mode;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [4:0] pa1, pa2, pb1, pb2;

  gpc3111_5_checker_if a_if ();
  gpc3111_5_checker_if b_if ();

  gpc3111_5_checker #(.DUT_LATENCY(0)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.master)
  );

  gpc3111_5_checker #(.DUT_LATENCY(2)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] f_exp(input logic [5:0] v);
    int s;
    s = v[0] + 2 * v[1] + 4 * v[2] + 8 * (v[3] + v[4] + v[5]);
    return 5'(s);
  endfunction

  wire [5:0] a_v = {a_if.src3, a_if.src2, a_if.src1, a_if.src0};
  wire [5:0] b_v = {b_if.src3, b_if.src2, b_if.src1, b_if.src0};

  // two-stage registered reference counters
  always @(posedge clk) begin
    pa1 <= f_exp(a_v);
    pa2 <= pa1;
    pb1 <= f_exp(b_v);
    pb2 <= pb1;
  end

  assign a_if.start = r_start & ~sel;
  assign b_if.start = r_start & sel;
  assign a_if.dst = (mode == 0) ? f_exp(a_v) :
                    (mode == 1) ? (f_exp(a_v) & 5'b10111) : pa2;
  assign b_if.dst = pb2;

  wire       w_busy = sel ? b_if.busy : a_if.busy;
  wire       w_done = sel ? b_if.done : a_if.done;
  wire       w_pass = sel ? b_if.pass : a_if.pass;
  wire [6:0] w_err  = sel ? b_if.err_count : a_if.err_count;
  wire [5:0] w_fvec = sel ? b_if.first_err_vec : a_if.first_err_vec;
  wire [4:0] w_fdst = sel ? b_if.first_err_dst : a_if.first_err_dst;
  wire [5:0] w_src  = sel ? b_v : a_v;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(w_busy), 0);
    chk({tag, "_done"}, 32'(w_done), 0);
    chk({tag, "_pass"}, 32'(w_pass), 0);
    chk({tag, "_err"},  32'(w_err),  0);
    chk({tag, "_fvec"}, 32'(w_fvec), 0);
    chk({tag, "_fdst"}, 32'(w_fdst), 0);
    chk({tag, "_src"},  32'(w_src),  0);
  endtask

  task automatic kick();
    r_start = 1'b1;
    @(posedge clk);
    #1;
    r_start = 1'b0;
    chk("start_busy", 32'(w_busy), 1);
    chk("start_src0", 32'(w_src), 0);
  endtask

  task automatic finish_run(input rec_t r, input int n0);
    int n;
    bit ok;
    n  = n0;
    ok = 1'b1;
    while (!w_done && n < 200) begin
      r_start = (n == r.poke);
      @(posedge clk);
      #1;
      r_start = 1'b0;
      n++;
      if (!w_done) begin
        if (w_busy !== 1'b1) ok = 1'b0;
        if (n < 64 && w_src != 6'(n)) ok = 1'b0;
        if (n >= 64 && w_src != 6'd0) ok = 1'b0;
      end
    end
    chk("run_len",  n, r.len);
    chk("run_seq",  32'(ok), 1);
    chk("end_busy", 32'(w_busy), 0);
    chk("end_src",  32'(w_src), 0);
    chk("end_pass", 32'(w_pass), r.pass);
    chk("end_err",  32'(w_err), r.err);
    chk("end_fvec", 32'(w_fvec), r.fvec);
    chk("end_fdst", 32'(w_fdst), r.fdst);
  endtask

  rec_t recs[5];
  rec_t r_ok;
  rec_t r_stk;

  initial begin
    recs[0] = '{0, 0, -1, 64, 1, 0,  0, 0};
    recs[1] = '{0, 1, -1, 64, 0, 32, 8, 0};
    recs[2] = '{0, 2, -1, 64, 0, 63, 1, 0};
    recs[3] = '{1, 2, -1, 66, 1, 0,  0, 0};
    recs[4] = '{0, 0, 16, 64, 1, 0,  0, 0};
    r_ok  = recs[0];
    r_stk = recs[1];

    rst     = 1'b1;
    r_start = 1'b0;
    sel     = 1'b0;
    mode    = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("rstA");
    sel = 1'b1;
    #1;
    chk_zero("rstB");

    for (int i = 0; i < 5; i++) begin
      sel  = recs[i].sel[0];
      mode = recs[i].mode;
      @(posedge clk);
      #1;
      kick();
      finish_run(recs[i], 0);
      @(posedge clk);
      #1;
      chk("done_drop", 32'(w_done), 0);
      chk("idle_busy", 32'(w_busy), 0);
    end

    // start accepted in the DONE cycle
    sel  = 1'b0;
    mode = 1;
    kick();
    finish_run(r_stk, 0);
    mode    = 0;
    r_start = 1'b1;
    @(posedge clk);
    #1;
    r_start = 1'b0;
    chk("rd_done", 32'(w_done), 0);
    chk("rd_busy", 32'(w_busy), 1);
    chk("rd_err",  32'(w_err), 0);
    chk("rd_pass", 32'(w_pass), 0);
    chk("rd_fvec", 32'(w_fvec), 0);
    chk("rd_src",  32'(w_src), 0);
    @(posedge clk);
    #1;
    chk("rd_src1", 32'(w_src), 1);
    finish_run(r_ok, 1);

    // reset while vector 0x20 is on src
    @(posedge clk);
    #1;
    kick();
    repeat (32) @(posedge clk);
    #1;
    chk("mid_src", 32'(w_src), 32);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("mid_rst");
    begin
      bit saw;
      saw = 1'b0;
      repeat (80) begin
        @(posedge clk);
        #1;
        if (w_done || w_busy) saw = 1'b1;
      end
      chk("no_done", 32'(saw), 0);
    end
    kick();
    finish_run(r_ok, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
